pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline with a multi-cycle multiplier in EX. It drives the 2-bit forwarding selects of both EX operand muxes, and detects load-use hazards and multiply occupancy. It generates the PC/IF-ID hold and ID-EX/EX-MEM bubble controls, sequences the multiplier start, and keeps a saturating stall-cycle counter for performance checks.

Parameters:
REG_ADDR_W, 5, register index width
MULT_LAT, 2, multiplier latency in cycles (>=1); EX is occupied MULT_LAT cycles per multiply
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_rs1  input  REG_ADDR_W  rs1 of instruction in ID
id_rs2  input  REG_ADDR_W  rs2 of instruction in ID
ex_valid  input  1  EX holds a real (non-bubble) instruction
ex_rs1  input  REG_ADDR_W  rs1 of instruction in EX
ex_rs2  input  REG_ADDR_W  rs2 of instruction in EX
ex_rd  input  REG_ADDR_W  rd of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_is_mult  input  1  EX instruction is a multiply
mem_rd  input  REG_ADDR_W  rd in EX/MEM register
mem_reg_write  input  1  EX/MEM writes rd
wb_rd  input  REG_ADDR_W  rd in MEM/WB register
wb_reg_write  input  1  MEM/WB writes rd
fw_sel_a  output  2  forwarding select, operand A
fw_sel_b  output  2  forwarding select, operand B
stall_pc  output  1  hold PC
stall_ifid  output  1  hold IF/ID register
hold_idex  output  1  hold ID/EX register (multiply in progress)
bubble_idex  output  1  load zeroed controls into ID/EX
bubble_exmem  output  1  load zeroed controls into EX/MEM
mult_start  output  1  one-cycle pulse; multiplier latches operands
mult_busy  output  1  multiplier occupying EX
stall_count  output  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Forwarding (combinational, every cycle, independent of state), per operand X in {rs1->a, rs2->b}:
  - 2'b10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_X (EX/MEM result).
  - Else 2'b01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_X (writeback value).
  - Else 2'b00 (register file). 2'b11 is never driven.
  - EX/MEM has priority over MEM/WB.
- State machine, registered, states RUN and MUL_WAIT; down-counter cnt of width clog2(MULT_LAT)+1.
- RUN, multiply entry: ex_valid && ex_is_mult && MULT_LAT>1.
  - Same cycle (combinational): mult_start=1, mult_busy=1, stall_pc=stall_ifid=hold_idex=bubble_exmem=1, bubble_idex=0.
  - Next edge: cnt<=MULT_LAT-2, state<=MUL_WAIT.
- RUN, multiply with MULT_LAT==1: mult_start=1 for one cycle, no stall, state stays RUN.
- RUN, load-use: only when no multiply entry; ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - stall_pc=stall_ifid=bubble_idex=1; hold_idex=bubble_exmem=0.
  - Exactly one stall cycle, since the bubble removes the condition next cycle. State stays RUN.
- MUL_WAIT:
  - mult_busy=1, mult_start=0.
  - cnt!=0: stall_pc=stall_ifid=hold_idex=bubble_exmem=1, cnt<=cnt-1.
  - cnt==0: all stall/bubble outputs 0 (result advances to EX/MEM), state<=RUN.
  - Load-use detection is suppressed in MUL_WAIT.
- Total stall per multiply = MULT_LAT-1 cycles; the instruction behind the multiply never re-triggers, because EX advances in the cnt==0 cycle.
- Back-to-back multiplies: the second is detected in RUN on the cycle after MUL_WAIT exits, giving a new mult_start and stall.
- stall_count increments on every edge where stall_pc=1; it holds at 2^CNT_W-1 (saturates, no wrap).
- Reset (sync, highest priority, any state including mid-multiply): state=RUN, cnt=0, stall_count=0. All stall, bubble and mult outputs are 0 in the cycle after the reset edge, provided the inputs present no hazard. The interrupted multiply is abandoned.
- Outputs without registers (selects, stalls, bubbles, mult_start) are pure functions of the current state, cnt and inputs; no output depends on X inputs when ex_valid=0, except fw_sel.

Test Plan:
- Forwarding priority: ex_rs1=5, mem_rd=5/mem_reg_write=1, wb_rd=5/wb_reg_write=1 -> fw_sel_a=2'b10. Drop mem_reg_write -> 2'b01. Set rd=0 in both -> 2'b00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7 -> exactly one cycle of stall_pc=stall_ifid=bubble_idex=1 and stall_count=1. With ex_rd=0 -> no stall.
- Multiply, MULT_LAT=4: ex_is_mult asserted in EX -> mult_start for 1 cycle, stall_pc high for exactly 3 cycles, mult_busy for 4 cycles, then RUN; stall_count=3.
- Two consecutive multiplies, MULT_LAT=2 -> two separate mult_start pulses 2 cycles apart, 1 stall cycle each; stall_count=2.
- Reset mid-multiply: rst asserted in the 2nd MUL_WAIT cycle (MULT_LAT=4) -> next cycle state RUN, all stalls 0, stall_count=0.
- Saturation: CNT_W=3, hold a multiply stream giving 10 stall cycles -> stall_count stops at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage pipeline whose EX stage
// contains a multi-cycle multiplier.
//
//   * Forwarding: fw_sel_a / fw_sel_b pick the EX operand source
//       2'b10 = EX/MEM result, 2'b01 = MEM/WB value, 2'b00 = register file.
//   * Load-use: a load in EX whose rd feeds the instruction in ID stalls
//     PC and IF/ID for one cycle and injects a bubble into ID/EX.
//   * Multiply: a multiply in EX occupies EX for MULT_LAT cycles. The first
//     MULT_LAT-1 of them hold PC, IF/ID and ID/EX and bubble EX/MEM. In the
//     last one the result advances to EX/MEM.
//   * stall_count: saturating count of cycles with stall_pc asserted.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1, id_rs2            source registers of the instruction in ID
//   ex_valid, ex_rs1, ex_rs2,
//   ex_rd, ex_mem_read,
//   ex_is_mult                description of the instruction in EX
//   mem_rd, mem_reg_write     destination in the EX/MEM register
//   wb_rd, wb_reg_write       destination in the MEM/WB register
//   fw_sel_a, fw_sel_b        forwarding selects
//   stall_pc, stall_ifid      hold PC / IF-ID
//   hold_idex                 hold ID/EX while a multiply is in progress
//   bubble_idex, bubble_exmem load zeroed controls into ID/EX / EX/MEM
//   mult_start                one-cycle pulse: multiplier latches operands
//   mult_busy                 multiplier occupies EX
//   stall_count               saturating stall-cycle counter
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MULT_LAT   = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_is_mult,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fw_sel_a,
    output logic [1:0]            fw_sel_b,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  hold_idex,
    output logic                  bubble_idex,
    output logic                  bubble_exmem,
    output logic                  mult_start,
    output logic                  mult_busy,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int CW        = $clog2(MULT_LAT) + 1;
    // The entry cycle itself is the first stall cycle, so the wait counter
    // starts two below the latency (only meaningful when MULT_LAT > 1).
    localparam int WAIT_INIT = (MULT_LAT > 1) ? (MULT_LAT - 2) : 0;

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_count_reg;

    // -------------------------------------------------------------------------
    // Forwarding: one identical select per EX operand.
    // -------------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] ex_src [2];
    logic [1:0]            fw_sel [2];

    assign ex_src[0] = ex_rs1;
    assign ex_src[1] = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_mem;
            logic hit_wb;
            // x0 is hard-wired zero, so a write to it must never be forwarded.
            assign hit_mem = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src[gi]);
            assign hit_wb  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_src[gi]);
            // EX/MEM holds the younger value and wins over MEM/WB.
            assign fw_sel[gi] = hit_mem ? 2'b10 :
                                hit_wb  ? 2'b01 : 2'b00;
        end
    endgenerate

    assign fw_sel_a = fw_sel[0];
    assign fw_sel_b = fw_sel[1];

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic mult_in_ex;
    logic mult_entry;
    logic load_use;

    assign mult_in_ex = ex_valid && ex_is_mult;
    assign mult_entry = mult_in_ex && (MULT_LAT > 1);
    assign load_use   = ex_valid && ex_mem_read && (ex_rd != '0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        hold_idex    = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        mult_start   = 1'b0;
        mult_busy    = 1'b0;

        case (state_reg)
            RUN: begin
                if (mult_entry) begin
                    mult_start   = 1'b1;
                    mult_busy    = 1'b1;
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    hold_idex    = 1'b1;
                    bubble_exmem = 1'b1;
                    cnt_next     = CW'(WAIT_INIT);
                    state_next   = MUL_WAIT;
                end else begin
                    // Single-cycle multiplier: just latch operands, no stall.
                    mult_start = mult_in_ex;
                    if (load_use) begin
                        // The bubble clears the hazard, so this lasts one cycle.
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                end
            end

            MUL_WAIT: begin
                mult_busy = 1'b1;
                if (cnt_reg != '0) begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    hold_idex    = 1'b1;
                    bubble_exmem = 1'b1;
                    cnt_next     = cnt_reg - CW'(1);
                end else begin
                    // Last occupied cycle: EX advances, so the instruction
                    // behind the multiply is not re-detected as a multiply.
                    state_next = RUN;
                end
            end

            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            cnt_reg         <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (stall_pc && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Three controllers share one input bus:
//   u_a : MULT_LAT=4, CNT_W=32
//   u_b : MULT_LAT=2, CNT_W=32
//   u_c : MULT_LAT=2, CNT_W=3   (saturation)
// A reference model tracks, per instance, the number of EX-occupancy cycles
// left for the multiply in flight and the expected stall counter, and every
// cycle all outputs of all instances are compared against it. A vector table,
// hand-written multi-cycle sequences and a random run drive the inputs.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       ex_valid;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_mem_read, ex_is_mult;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;

    logic [1:0]  o_fa [3];
    logic [1:0]  o_fb [3];
    logic        o_sp [3];
    logic        o_si [3];
    logic        o_hi [3];
    logic        o_bi [3];
    logic        o_be [3];
    logic        o_ms [3];
    logic        o_mb [3];
    logic [31:0] o_sc [3];
    logic [31:0] sc_a, sc_b;
    logic [2:0]  sc_c;

    assign o_sc[0] = sc_a;
    assign o_sc[1] = sc_b;
    assign o_sc[2] = {29'd0, sc_c};

    int lat_p [3] = '{4, 2, 2};
    int cw_p  [3] = '{32, 32, 3};

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MULT_LAT(4), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fw_sel_a(o_fa[0]), .fw_sel_b(o_fb[0]), .stall_pc(o_sp[0]),
        .stall_ifid(o_si[0]), .hold_idex(o_hi[0]), .bubble_idex(o_bi[0]),
        .bubble_exmem(o_be[0]), .mult_start(o_ms[0]), .mult_busy(o_mb[0]),
        .stall_count(sc_a));

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MULT_LAT(2), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fw_sel_a(o_fa[1]), .fw_sel_b(o_fb[1]), .stall_pc(o_sp[1]),
        .stall_ifid(o_si[1]), .hold_idex(o_hi[1]), .bubble_idex(o_bi[1]),
        .bubble_exmem(o_be[1]), .mult_start(o_ms[1]), .mult_busy(o_mb[1]),
        .stall_count(sc_b));

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MULT_LAT(2), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fw_sel_a(o_fa[2]), .fw_sel_b(o_fb[2]), .stall_pc(o_sp[2]),
        .stall_ifid(o_si[2]), .hold_idex(o_hi[2]), .bubble_idex(o_bi[2]),
        .bubble_exmem(o_be[2]), .mult_start(o_ms[2]), .mult_busy(o_mb[2]),
        .stall_count(sc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int    total_checks  = 0;
    int    passed_checks = 0;
    string phase = "init";

    task automatic chk(input string name, input longint act, input longint exp);
        total_checks++;
        if (act == exp) passed_checks++;
        else $display("FAIL %s %s: got %0d expected %0d", phase, name, act, exp);
    endtask

    // -------------------------------------------------------------------------
    // Reference model: busy_left = EX-occupancy cycles still to come for the
    // multiply in flight (0 = idle). model_cnt = expected stall_count.
    // -------------------------------------------------------------------------
    int     busy_left [3];
    longint model_cnt [3];
    bit     e_stall   [3];
    bit     e_entry   [3];

    function automatic int fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 1;
        return 0;
    endfunction

    // Wait for the falling edge and compare every output of every instance.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bit st, hd, bi, be, ms, mb, mul, lu;
            st = 0; hd = 0; bi = 0; be = 0; ms = 0; mb = 0;
            mul = ex_valid && ex_is_mult;
            lu  = ex_valid && ex_mem_read && ex_rd != 0 &&
                  (ex_rd == id_rs1 || ex_rd == id_rs2);
            e_entry[i] = 0;
            if (busy_left[i] == 0) begin
                if (mul && lat_p[i] > 1) begin
                    e_entry[i] = 1;
                    st = 1; hd = 1; be = 1; ms = 1; mb = 1;
                end else begin
                    ms = mul;
                    if (lu) begin st = 1; bi = 1; end
                end
            end else begin
                mb = 1;
                if (busy_left[i] > 1) begin st = 1; hd = 1; be = 1; end
            end
            e_stall[i] = st;
            chk($sformatf("dut%0d fw_sel_a", i),     o_fa[i], fwd(ex_rs1));
            chk($sformatf("dut%0d fw_sel_b", i),     o_fb[i], fwd(ex_rs2));
            chk($sformatf("dut%0d stall_pc", i),     o_sp[i], st);
            chk($sformatf("dut%0d stall_ifid", i),   o_si[i], st);
            chk($sformatf("dut%0d hold_idex", i),    o_hi[i], hd);
            chk($sformatf("dut%0d bubble_idex", i),  o_bi[i], bi);
            chk($sformatf("dut%0d bubble_exmem", i), o_be[i], be);
            chk($sformatf("dut%0d mult_start", i),   o_ms[i], ms);
            chk($sformatf("dut%0d mult_busy", i),    o_mb[i], mb);
            chk($sformatf("dut%0d stall_count", i),  o_sc[i], model_cnt[i]);
        end
    endtask

    // Update the model with the values present at the coming edge, then pass it.
    task automatic advance();
        for (int i = 0; i < 3; i++) begin
            longint maxv;
            maxv = (64'd1 << cw_p[i]) - 1;
            if (rst) begin
                busy_left[i] = 0;
                model_cnt[i] = 0;
            end else begin
                if (e_stall[i] && model_cnt[i] < maxv) model_cnt[i]++;
                if (busy_left[i] == 0) begin
                    if (e_entry[i]) busy_left[i] = lat_p[i] - 1;
                end else begin
                    busy_left[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_is_mult = 0; mem_rd = 0; mem_reg_write = 0;
        wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        sample();
        advance();
        rst = 0;
    endtask

    // -------------------------------------------------------------------------
    // Vector table (single-cycle, from RUN state)
    // -------------------------------------------------------------------------
    typedef struct {
        logic [4:0] ers1, ers2, mrd;
        logic       mwe;
        logic [4:0] wrd;
        logic       wwe;
        logic       ld;
        logic [4:0] erd, irs1, irs2;
        logic [1:0] ea, eb;
        logic       est;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int first_start, second_start, n_stall, n_busy, n_start;

        vecs[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0};
        vecs[1] = '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0};
        vecs[2] = '{5'd5, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[3] = '{5'd3, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b10, 1'b0};
        vecs[4] = '{5'd6, 5'd6, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[5] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 2'b00, 2'b00, 1'b1};
        vecs[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd2, 2'b00, 2'b00, 1'b1};
        vecs[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd10, 2'b00, 2'b00, 1'b0};

        for (int i = 0; i < 3; i++) begin busy_left[i] = 0; model_cnt[i] = 0; end
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        phase = "reset";
        sample();
        chk("stall_count after reset", o_sc[0], 0);
        chk("mult_busy after reset", o_mb[0], 0);
        advance();

        // Table
        for (int v = 0; v < 9; v++) begin
            phase = $sformatf("vec%0d", v);
            idle();
            ex_rs1 = vecs[v].ers1; ex_rs2 = vecs[v].ers2;
            mem_rd = vecs[v].mrd;  mem_reg_write = vecs[v].mwe;
            wb_rd  = vecs[v].wrd;  wb_reg_write  = vecs[v].wwe;
            ex_valid = vecs[v].ld; ex_mem_read = vecs[v].ld;
            ex_rd = vecs[v].erd; id_rs1 = vecs[v].irs1; id_rs2 = vecs[v].irs2;
            sample();
            chk("table fw_sel_a", o_fa[0], vecs[v].ea);
            chk("table fw_sel_b", o_fb[0], vecs[v].eb);
            chk("table stall_pc", o_sp[0], vecs[v].est);
            advance();
            $display("vec %0d: fw_a=%0d fw_b=%0d stall=%0d", v, o_fa[0], o_fb[0], o_sp[0]);
        end

        // Load-use: one stall, then the bubble removes the hazard
        phase = "load_use";
        do_reset();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
        sample();
        chk("lu stall_pc", o_sp[0], 1);
        chk("lu bubble_idex", o_bi[0], 1);
        advance();
        idle();
        sample();
        chk("lu stall_pc after bubble", o_sp[0], 0);
        chk("lu stall_count", o_sc[0], 1);
        advance();
        $display("load_use: stall_count=%0d", o_sc[0]);

        // Multiply on MULT_LAT=4
        phase = "mult4";
        do_reset();
        n_stall = 0; n_busy = 0; n_start = 0;
        ex_valid = 1; ex_is_mult = 1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 4) ex_is_mult = 0;
            sample();
            n_stall += o_sp[0]; n_busy += o_mb[0]; n_start += o_ms[0];
            advance();
        end
        idle();
        sample();
        chk("mult4 start pulses", n_start, 1);
        chk("mult4 stall cycles", n_stall, 3);
        chk("mult4 busy cycles", n_busy, 4);
        chk("mult4 stall_count", o_sc[0], 3);
        advance();
        $display("mult4: starts=%0d stalls=%0d busy=%0d", n_start, n_stall, n_busy);

        // Back-to-back multiplies on MULT_LAT=2
        phase = "mult2_b2b";
        do_reset();
        first_start = -1; second_start = -1; n_stall = 0;
        ex_valid = 1; ex_is_mult = 1;
        for (int c = 0; c < 5; c++) begin
            if (c >= 4) ex_is_mult = 0;
            sample();
            if (o_ms[1]) begin
                if (first_start < 0) first_start = c;
                else if (second_start < 0) second_start = c;
            end
            n_stall += o_sp[1];
            advance();
        end
        idle();
        sample();
        chk("b2b start spacing", second_start - first_start, 2);
        chk("b2b stall cycles", n_stall, 2);
        chk("b2b stall_count", o_sc[1], 2);
        advance();
        $display("mult2_b2b: starts at %0d and %0d", first_start, second_start);

        // Reset in the second MUL_WAIT cycle of MULT_LAT=4
        phase = "reset_mid_mult";
        do_reset();
        ex_valid = 1; ex_is_mult = 1;
        sample(); advance();   // entry
        sample(); advance();   // 1st MUL_WAIT
        rst = 1;
        sample(); advance();   // 2nd MUL_WAIT, reset edge
        rst = 0;
        idle();
        sample();
        chk("rmm stall_pc", o_sp[0], 0);
        chk("rmm mult_busy", o_mb[0], 0);
        chk("rmm stall_count", o_sc[0], 0);
        advance();
        $display("reset_mid_mult: stall=%0d busy=%0d count=%0d", o_sp[0], o_mb[0], o_sc[0]);

        // Saturation: 20 cycles of multiplies give 10 stalls on MULT_LAT=2
        phase = "saturate";
        do_reset();
        ex_valid = 1; ex_is_mult = 1;
        for (int c = 0; c < 20; c++) begin
            sample(); advance();
        end
        idle();
        sample();
        chk("sat 3-bit stall_count", o_sc[2], 7);
        chk("sat 32-bit stall_count", o_sc[1], 10);
        advance();
        $display("saturate: cnt3=%0d cnt32=%0d", o_sc[2], o_sc[1]);

        // Random stimulus against the model
        phase = "random";
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 49) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_rs1        = 5'($urandom_range(0, 3));
            ex_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_is_mult    = ($urandom_range(0, 3) == 0);
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_write = $urandom_range(0, 1);
            wb_rd         = 5'($urandom_range(0, 3));
            wb_reg_write  = $urandom_range(0, 1);
            sample();
            advance();
            if (c % 50 == 0)
                $display("random %0d: stall_count a=%0d b=%0d c=%0d", c, o_sc[0], o_sc[1], o_sc[2]);
        end
        rst = 0;

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
